// File: rtl/npu_ctrl_pkg.sv
// Shared types and defaults for the clk_cal-domain layer sequencer.
package npu_ctrl_pkg;

    localparam int unsigned TILE_CNT_W_DEF  = 8;
    localparam int unsigned PLS_STRETCH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PARA,
        ST_CAL_ISSUE,
        ST_CAL_WAIT,
        ST_TX_REQ,
        ST_TX_WAIT,
        ST_DONE
    } cal_state_e;

endpackage

// File: rtl/npu_pls_stretch.sv
// Stretches a 1-cycle trigger into a LEN-cycle pulse starting the next cycle;
// triggers arriving while the pulse is high are ignored.
import npu_ctrl_pkg::*;

module npu_pls_stretch #(
    parameter int unsigned LEN = PLS_STRETCH_DEF
) (
    input  logic clk_cal,
    input  logic rst_n,
    input  logic trig,
    output logic pls
);

    localparam int unsigned CW = $clog2(LEN);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_cal or negedge rst_n) begin
        if (!rst_n) begin
            pls <= 1'b0;
            cnt <= '0;
        end else if (pls) begin
            if (cnt == '0) pls <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end else if (trig) begin
            pls <= 1'b1;
            cnt <= CW'(LEN - 1);
        end
    end

endmodule

// File: rtl/npu_cal_ctrl.sv
// Layer-level compute sequencer (clk_cal domain): tiles -> OFM handoff -> done.
// Optional watchdog on CAL_WAIT/TX_WAIT enabled by defining NPU_CAL_TMO_EN.
import npu_ctrl_pkg::*;

module npu_cal_ctrl #(
    parameter int unsigned TILE_CNT_W  = TILE_CNT_W_DEF,
`ifdef NPU_CAL_TMO_EN
    parameter int unsigned TMO_W       = 16,
`endif
    parameter int unsigned PLS_STRETCH = PLS_STRETCH_DEF
) (
    input  logic                  clk_cal,
    input  logic                  rst_n,
    input  logic                  pe_cal_start_sync,
    input  logic                  pe_ifm_rst_sync,
    input  logic                  pe_wt_rst_sync,
    input  logic                  pe_first_bn_sync,
    input  logic                  pe_ft_lyr_para_done_sync,
    input  logic                  pe_tx_ofm_done_sync,
    input  logic [TILE_CNT_W-1:0] lyr_tile_num,
    input  logic                  tile_done,
`ifdef NPU_CAL_TMO_EN
    input  logic [TMO_W-1:0]      tmo_limit,
    output logic                  err_tmo,
`endif
    output logic                  tile_start,
    output logic [TILE_CNT_W-1:0] tile_idx,
    output logic                  first_bn_lat,
    output logic                  ifm_buf_clr,
    output logic                  wt_buf_clr,
    output logic                  pe_tx_ofm_start,
    output logic                  pe_cal_done,
    output logic                  busy,
    output logic                  err_start_busy
);

    localparam int unsigned PCW = $clog2(PLS_STRETCH);

    cal_state_e            state;
    logic [TILE_CNT_W-1:0] tile_num;
    logic [TILE_CNT_W-1:0] num_eff;
    logic                  para_vld;
    logic                  tx_seen;
    logic [PCW-1:0]        pls_cnt;
    logic                  last_tile;
    logic                  tmo_hit;
    logic                  tx_go;
    logic                  done_go;
`ifdef NPU_CAL_TMO_EN
    logic [TMO_W-1:0]      tmo_cnt;
`endif

    // Transition strobes are decoded combinationally so the stretched pulses
    // line up with the first cycle of TX_REQ / DONE.
    always_comb begin
        tmo_hit = 1'b0;
`ifdef NPU_CAL_TMO_EN
        tmo_hit = ((state == ST_CAL_WAIT) || (state == ST_TX_WAIT)) &&
                  (tmo_cnt == tmo_limit - 1'b1);
`endif
        num_eff   = pe_ft_lyr_para_done_sync ? lyr_tile_num : tile_num;
        last_tile = (tile_idx == tile_num - 1'b1);
        tx_go     = (state == ST_CAL_WAIT) && tile_done && last_tile && !tmo_hit;
        done_go   = tmo_hit ||
                    ((state == ST_CAL_ISSUE) && (tile_num == '0)) ||
                    ((state == ST_TX_WAIT) && (pe_tx_ofm_done_sync || tx_seen));
    end

    always_ff @(posedge clk_cal or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            tile_idx       <= '0;
            tile_num       <= '0;
            para_vld       <= 1'b0;
            tx_seen        <= 1'b0;
            pls_cnt        <= '0;
            tile_start     <= 1'b0;
            first_bn_lat   <= 1'b0;
            ifm_buf_clr    <= 1'b0;
            wt_buf_clr     <= 1'b0;
            busy           <= 1'b0;
            err_start_busy <= 1'b0;
`ifdef NPU_CAL_TMO_EN
            tmo_cnt        <= '0;
            err_tmo        <= 1'b0;
`endif
        end else begin
            ifm_buf_clr <= pe_ifm_rst_sync;
            wt_buf_clr  <= pe_wt_rst_sync;
            tile_start  <= 1'b0;

            if (pe_cal_start_sync && (state != ST_IDLE)) err_start_busy <= 1'b1;

            if (done_go) para_vld <= 1'b0;
            if (pe_ft_lyr_para_done_sync) begin
                para_vld <= 1'b1;
                if ((state == ST_IDLE) || (state == ST_WAIT_PARA)) tile_num <= lyr_tile_num;
            end

`ifdef NPU_CAL_TMO_EN
            if ((state == ST_CAL_WAIT) || (state == ST_TX_WAIT)) tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err_tmo <= 1'b1;
`endif

            case (state)
                ST_IDLE: begin
                    if (pe_cal_start_sync) begin
                        first_bn_lat <= pe_first_bn_sync;
                        tile_idx     <= '0;
                        busy         <= 1'b1;
                        if (para_vld || pe_ft_lyr_para_done_sync) begin
                            state      <= ST_CAL_ISSUE;
                            tile_start <= (num_eff != '0);
                        end else begin
                            state <= ST_WAIT_PARA;
                        end
                    end
                end
                ST_WAIT_PARA: begin
                    if (pe_ft_lyr_para_done_sync) begin
                        state      <= ST_CAL_ISSUE;
                        tile_start <= (lyr_tile_num != '0);
                    end
                end
                ST_CAL_ISSUE: begin
                    state <= done_go ? ST_DONE : ST_CAL_WAIT;
`ifdef NPU_CAL_TMO_EN
                    tmo_cnt <= '0;
`endif
                end
                ST_CAL_WAIT: begin
                    if (tmo_hit) begin
                        state <= ST_DONE;
                    end else if (tile_done) begin
                        if (last_tile) begin
                            state   <= ST_TX_REQ;
                            tx_seen <= 1'b0;
                            pls_cnt <= '0;
                        end else begin
                            state      <= ST_CAL_ISSUE;
                            tile_idx   <= tile_idx + 1'b1;
                            tile_start <= 1'b1;
                        end
                    end
                end
                ST_TX_REQ: begin
                    if (pe_tx_ofm_done_sync) tx_seen <= 1'b1;
                    if (pls_cnt == PCW'(PLS_STRETCH - 1)) begin
                        state <= ST_TX_WAIT;
`ifdef NPU_CAL_TMO_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
                        pls_cnt <= pls_cnt + 1'b1;
                    end
                end
                ST_TX_WAIT: begin
                    if (done_go) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (pls_cnt == PCW'(PLS_STRETCH - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        pls_cnt <= pls_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (done_go) pls_cnt <= '0;
        end
    end

    npu_pls_stretch #(.LEN(PLS_STRETCH)) u_tx_pls (
        .clk_cal (clk_cal),
        .rst_n   (rst_n),
        .trig    (tx_go),
        .pls     (pe_tx_ofm_start)
    );

    npu_pls_stretch #(.LEN(PLS_STRETCH)) u_done_pls (
        .clk_cal (clk_cal),
        .rst_n   (rst_n),
        .trig    (done_go),
        .pls     (pe_cal_done)
    );

endmodule

// File: tb/tb_npu_cal_ctrl.sv
// Self-checking bench for npu_cal_ctrl: per-layer schedules -> expected traces.
module tb_npu_cal_ctrl;

    localparam int NC = 4096;

    logic       clk_cal = 1'b0;
    logic       rst_n;
    logic       pe_cal_start_sync, pe_ifm_rst_sync, pe_wt_rst_sync, pe_first_bn_sync;
    logic       pe_ft_lyr_para_done_sync, pe_tx_ofm_done_sync, tile_done;
    logic [7:0] lyr_tile_num;
    logic       tile_start, first_bn_lat, ifm_buf_clr, wt_buf_clr;
    logic       pe_tx_ofm_start, pe_cal_done, busy, err_start_busy;
    logic [7:0] tile_idx;
`ifdef NPU_CAL_TMO_EN
    logic [15:0] tmo_limit = '0;
    logic        err_tmo;
`endif

    always #5 clk_cal = ~clk_cal;

    npu_cal_ctrl dut (
        .clk_cal                  (clk_cal),
        .rst_n                    (rst_n),
        .pe_cal_start_sync        (pe_cal_start_sync),
        .pe_ifm_rst_sync          (pe_ifm_rst_sync),
        .pe_wt_rst_sync           (pe_wt_rst_sync),
        .pe_first_bn_sync         (pe_first_bn_sync),
        .pe_ft_lyr_para_done_sync (pe_ft_lyr_para_done_sync),
        .pe_tx_ofm_done_sync      (pe_tx_ofm_done_sync),
        .lyr_tile_num             (lyr_tile_num),
        .tile_done                (tile_done),
`ifdef NPU_CAL_TMO_EN
        .tmo_limit                (tmo_limit),
        .err_tmo                  (err_tmo),
`endif
        .tile_start               (tile_start),
        .tile_idx                 (tile_idx),
        .first_bn_lat             (first_bn_lat),
        .ifm_buf_clr              (ifm_buf_clr),
        .wt_buf_clr               (wt_buf_clr),
        .pe_tx_ofm_start          (pe_tx_ofm_start),
        .pe_cal_done              (pe_cal_done),
        .busy                     (busy),
        .err_start_busy           (err_start_busy)
    );

    // stimulus per cycle
    bit       s_rst[NC], s_start[NC], s_ifm[NC], s_wt[NC], s_fb[NC];
    bit       s_para[NC], s_txd[NC], s_tdone[NC];
    bit [7:0] s_num[NC];
    // expected per cycle
    bit       e_ts[NC], e_tx[NC], e_cd[NC], e_busy[NC], e_fb[NC], e_err[NC], e_ifm[NC], e_wt[NC];
    int       e_idx[NC];
    // model events
    bit       ev_idx[NC], ev_fb[NC], ev_fbv[NC], ev_err[NC];
    int       ev_idxv[NC];

    int  cb;
    int  cyc;
    int  nrun;
    bit  chk_en = 1'b0;
    int  total = 0;
    int  bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    // One layer: mode 0 = params before start, 1 = same cycle, 2 = params pgap after start.
    // tdly/txdly of 0 mean random; inj > 0 is a busy-time cal_start cycle.
    task automatic build_layer(input int n, input int mode, input int pgap, input int tdly,
                               input int txdly, input int inj, input int gap, input bit rnd,
                               input bit kill, output int e_out);
        int t0, tp, s, s_first, e, x, dd, lastc;
        t0 = cb; tp = cb;
        if (mode == 0) t0 = cb + pgap;
        else if (mode == 2) tp = cb + pgap;
        s = (mode == 2) ? tp + 1 : t0 + 1;
        s_first = s;
        s_start[t0] = 1'b1;
        s_para[tp]  = 1'b1;
        s_num[tp]   = 8'(n);
        ev_idx[t0+1] = 1'b1; ev_idxv[t0+1] = 0;
        ev_fb[t0+1]  = 1'b1; ev_fbv[t0+1]  = s_fb[t0];
        e = s;
        if (n == 0) begin
            dd = s + 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                e_ts[s] = 1'b1;
                ev_idx[s] = 1'b1; ev_idxv[s] = i;
                e = s + ((tdly > 0) ? tdly : int'($urandom_range(1, 6)));
                s_tdone[e] = 1'b1;
                s = e + 1;
            end
            for (int k = 1; k <= 4; k++) e_tx[e+k] = 1'b1;
            x = e + ((txdly > 0) ? txdly : int'($urandom_range(1, 10)));
            if (!kill) s_txd[x] = 1'b1;
            dd = ((x > e + 5) ? x : e + 5) + 1;
        end
        for (int c = t0 + 1; c <= dd + 3; c++) e_busy[c] = 1'b1;
        for (int c = dd; c <= dd + 3; c++) e_cd[c] = 1'b1;
        lastc = inj;
        if (rnd && $urandom_range(0, 9) < 4) lastc = int'($urandom_range(t0 + 1, dd + 3));
        if (lastc > 0) begin
            s_start[lastc] = 1'b1;
            ev_err[lastc+1] = 1'b1;
        end
        if (rnd && $urandom_range(0, 2) == 0) s_tdone[dd+1] = 1'b1;
        if (rnd && $urandom_range(0, 2) == 0) s_txd[s_first] = 1'b1;
        e_out = e;
        cb = dd + 4 + gap;
    endtask

    initial begin
        int eo, r, nl;
        bit cfb, cerr;
        int cidx;

        rst_n = 1'b0;
        pe_cal_start_sync = 0; pe_ifm_rst_sync = 0; pe_wt_rst_sync = 0; pe_first_bn_sync = 0;
        pe_ft_lyr_para_done_sync = 0; pe_tx_ofm_done_sync = 0; tile_done = 0; lyr_tile_num = '0;

        for (int c = 0; c < NC; c++) begin
            s_rst[c] = (c >= 4);
            s_fb[c]  = 1'($urandom_range(0, 1));
            s_num[c] = 8'($urandom_range(0, 255));
            s_ifm[c] = ($urandom_range(0, 9) == 0);
            s_wt[c]  = ($urandom_range(0, 9) == 0);
        end

        cb = 6;
        build_layer(3, 0, 1, 5, 8, 0, 2, 1'b0, 1'b0, eo);
        build_layer(1, 2, 10, 3, 2, 0, 2, 1'b0, 1'b0, eo);
        build_layer(0, 1, 0, 0, 0, 0, 2, 1'b0, 1'b0, eo);
        build_layer(2, 0, 1, 5, 6, 78, 2, 1'b0, 1'b0, eo);
        s_ifm[80] = 1'b1; s_wt[80] = 1'b1;
        nl = 0;
        while (cb < 2600 && nl < 40) begin
            int md;
            md = int'($urandom_range(0, 2));
            build_layer(int'($urandom_range(0, 5)), md,
                        (md == 2) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 3)),
                        0, 0, 0, int'($urandom_range(0, 3)), 1'b1, 1'b0, eo);
            nl++;
        end
        // layer killed by reset while the OFM request pulse is high
        build_layer(2, 1, 0, 3, 10, 0, 0, 1'b0, 1'b1, eo);
        r = eo + 2;
        for (int c = r; c <= r + 15; c++) begin
            e_busy[c] = 0; e_tx[c] = 0; e_cd[c] = 0; e_ts[c] = 0;
        end
        for (int c = r; c <= r + 2; c++) s_rst[c] = 1'b0;
        cb = r + 16;
        build_layer(2, 2, 4, 0, 0, 0, 0, 1'b0, 1'b0, eo);
        nrun = cb + 6;

        cidx = 0; cfb = 0; cerr = 0;
        for (int c = 0; c < NC; c++) begin
            if (!s_rst[c]) begin
                cidx = 0; cfb = 0; cerr = 0;
            end else begin
                if (ev_idx[c]) cidx = ev_idxv[c];
                if (ev_fb[c])  cfb  = ev_fbv[c];
                if (ev_err[c]) cerr = 1'b1;
            end
            e_idx[c] = cidx; e_fb[c] = cfb; e_err[c] = cerr;
            e_ifm[c] = (c > 0) && s_ifm[c-1] && s_rst[c-1] && s_rst[c];
            e_wt[c]  = (c > 0) && s_wt[c-1]  && s_rst[c-1] && s_rst[c];
        end

        // hand-derived anchors for the directed layers
        chk("pin_ts8", e_ts[8], 1);    chk("pin_ts14", e_ts[14], 1);
        chk("pin_ts20", e_ts[20], 1);  chk("pin_ts21", e_ts[21], 0);
        chk("pin_idx20", e_idx[20], 2);
        chk("pin_tx26", e_tx[26], 1);  chk("pin_tx29", e_tx[29], 1);  chk("pin_tx30", e_tx[30], 0);
        chk("pin_cd34", e_cd[34], 1);  chk("pin_cd37", e_cd[37], 1);  chk("pin_cd38", e_cd[38], 0);
        chk("pin_busy7", e_busy[7], 0); chk("pin_busy8", e_busy[8], 1); chk("pin_busy38", e_busy[38], 0);
        chk("pin_busy41", e_busy[41], 1); chk("pin_ts50", e_ts[50], 0); chk("pin_ts51", e_ts[51], 1);
        chk("pin_ts67", e_ts[67], 0);  chk("pin_cd68", e_cd[68], 1);  chk("pin_cd71", e_cd[71], 1);
        chk("pin_tx72", e_tx[72], 0);
        chk("pin_err78", e_err[78], 0); chk("pin_err79", e_err[79], 1);
        chk("pin_ifm81", e_ifm[81], 1);

        for (int c = 0; c < nrun; c++) begin
            @(posedge clk_cal);
            cyc = c;
            #1;
            rst_n                    = s_rst[c];
            pe_cal_start_sync        = s_start[c];
            pe_ifm_rst_sync          = s_ifm[c];
            pe_wt_rst_sync           = s_wt[c];
            pe_first_bn_sync         = s_fb[c];
            pe_ft_lyr_para_done_sync = s_para[c];
            pe_tx_ofm_done_sync      = s_txd[c];
            tile_done                = s_tdone[c];
            lyr_tile_num             = s_num[c];
            chk_en = 1'b1;
        end
        @(posedge clk_cal);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    always @(negedge clk_cal) begin
        if (chk_en) begin
            chk("tile_start",      int'(tile_start),      int'(e_ts[cyc]));
            chk("tile_idx",        int'(tile_idx),        e_idx[cyc]);
            chk("first_bn_lat",    int'(first_bn_lat),    int'(e_fb[cyc]));
            chk("ifm_buf_clr",     int'(ifm_buf_clr),     int'(e_ifm[cyc]));
            chk("wt_buf_clr",      int'(wt_buf_clr),      int'(e_wt[cyc]));
            chk("pe_tx_ofm_start", int'(pe_tx_ofm_start), int'(e_tx[cyc]));
            chk("pe_cal_done",     int'(pe_cal_done),     int'(e_cd[cyc]));
            chk("busy",            int'(busy),            int'(e_busy[cyc]));
            chk("err_start_busy",  int'(err_start_busy),  int'(e_err[cyc]));
        end
    end

endmodule

// File: doc/npu_cal_ctrl.md
Name: npu_cal_ctrl

Overview:
- Layer-level compute sequencer in the clk_cal domain.
- Consumes the synchronized single-cycle control pulses from the clk_trans domain.
- Sequences the PE array tile by tile, then hands the OFM off to the transfer side and reports layer completion.
- Drives pe_cal_done and pe_tx_ofm_start as stretched pulses so the slower clk_trans domain reliably edge-detects them.

Parameters:
- TILE_CNT_W, 8: width of tile count/index.
- PLS_STRETCH, 4: cycles each cross-domain output pulse is held high (min 2).
- TMO_W, 16: watchdog counter width (used only with the optional feature).

Ports:
- clk_cal  in  1  compute clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pe_cal_start_sync  in  1  1-cycle pulse, start layer compute.
- pe_ifm_rst_sync  in  1  1-cycle pulse, clear IFM buffer pointers.
- pe_wt_rst_sync  in  1  1-cycle pulse, clear weight buffer pointers.
- pe_first_bn_sync  in  1  level, current layer is first BN layer.
- pe_ft_lyr_para_done_sync  in  1  1-cycle pulse, layer parameters fetched.
- pe_tx_ofm_done_sync  in  1  1-cycle pulse, OFM transfer complete.
- lyr_tile_num  in  TILE_CNT_W  tiles in current layer; sampled on para_done.
- tile_done  in  1  1-cycle pulse from PE array, current tile finished.
- tile_start  out  1  1-cycle pulse to PE array, start tile tile_idx.
- tile_idx  out  TILE_CNT_W  index of the tile in progress.
- first_bn_lat  out  1  pe_first_bn_sync latched at layer start.
- ifm_buf_clr  out  1  registered copy of pe_ifm_rst_sync.
- wt_buf_clr  out  1  registered copy of pe_wt_rst_sync.
- pe_tx_ofm_start  out  1  stretched pulse, request OFM transfer.
- pe_cal_done  out  1  stretched pulse, layer complete.
- busy  out  1  FSM not in IDLE.
- err_start_busy  out  1  sticky; cal_start received while busy.

Behaviour:
- Reset: all outputs 0, FSM IDLE, tile_idx 0, para_vld flag 0, tile_num register 0.
- para_vld set on pe_ft_lyr_para_done_sync (tile_num register loaded the same cycle); cleared on entering DONE.
- ifm_buf_clr / wt_buf_clr: exactly 1-cycle latency from input pulse, in any state.
- FSM states IDLE, WAIT_PARA, CAL_ISSUE, CAL_WAIT, TX_REQ, TX_WAIT, DONE.
- IDLE:
  - on cal_start: latch first_bn_lat, tile_idx := 0.
  - go to CAL_ISSUE if para_vld (or para_done in the same cycle), else WAIT_PARA.
- WAIT_PARA: on para_done -> CAL_ISSUE next cycle.
- CAL_ISSUE:
  - if tile_num == 0, go directly to DONE (layer skipped, no TX).
  - else tile_start = 1 for this single cycle, -> CAL_WAIT.
- CAL_WAIT: on tile_done:
  - if tile_idx == tile_num-1 -> TX_REQ.
  - else tile_idx++ and -> CAL_ISSUE.
  - Minimum tile-to-tile spacing is 2 cycles.
- TX_REQ: pe_tx_ofm_start high for exactly PLS_STRETCH cycles, then -> TX_WAIT.
- TX_WAIT: on tx_ofm_done -> DONE. A tx_ofm_done arriving during TX_REQ is captured and honoured on TX_WAIT entry.
- DONE: pe_cal_done high for exactly PLS_STRETCH cycles, then -> IDLE.
- cal_start in any non-IDLE state: ignored, err_start_busy set; cleared only by reset.
- tile_done outside CAL_WAIT: ignored.
- para_done while busy: updates tile_num register only when in IDLE or WAIT_PARA; otherwise sets para_vld for the next layer without reloading.
- Stray tx_ofm_done outside TX_REQ/TX_WAIT: ignored.
- Reset mid-operation: immediate return to reset values; any stretched pulse is truncated.

Optional Feature:
- Macro NPU_CAL_TMO_EN.
- With it:
  - extra input tmo_limit [TMO_W] and output err_tmo (sticky).
  - A counter runs in CAL_WAIT and TX_WAIT and clears on each state entry.
  - When the count reaches tmo_limit: err_tmo set, FSM -> DONE (pe_cal_done still pulsed), para_vld cleared.
- Without it: no port, no counter; states wait indefinitely.

Decomposition:
- Package npu_ctrl_pkg: FSM state enum, PLS_STRETCH default, tile count width constant.
- Sub-module npu_pls_stretch (parameter LEN): 1-cycle trigger in -> LEN-cycle high out, with a retrigger-ignored-while-high rule.
- Instantiated twice, for pe_tx_ofm_start and pe_cal_done.

Test Plan:
- Para_done with lyr_tile_num=3, then cal_start, with tile_done 5 cycles after each tile_start:
  - tile_start pulses with tile_idx 0,1,2.
  - pe_tx_ofm_start high 4 cycles; after tx_ofm_done, pe_cal_done high 4 cycles.
  - busy returns to 0.
- cal_start before para_done, para_done 10 cycles later -> FSM in WAIT_PARA, first tile_start 1 cycle after para_done.
- lyr_tile_num=0 -> no tile_start, no pe_tx_ofm_start; pe_cal_done high 4 cycles.
- Second cal_start during CAL_WAIT -> err_start_busy=1, sequence unaffected.
- ifm_rst and wt_rst pulses during CAL_WAIT -> ifm_buf_clr and wt_buf_clr each high exactly 1 cycle, 1 cycle later, FSM unaffected.
- Reset asserted mid-TX_REQ (pe_tx_ofm_start high) -> output drops immediately; after release, IDLE with all outputs 0.
- With NPU_CAL_TMO_EN and tmo_limit=20, no tile_done -> err_tmo=1 after 20 cycles in CAL_WAIT, pe_cal_done pulsed.
